// File: rtl/rgb_to_bayer_tx.sv
// RGB pixel stream to raw Bayer (GRBG) sample stream with frame timing.
// Ready/valid input, one-cycle registered output, programmable active and blanking periods.
module rgb_to_bayer_tx #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 960,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_BLANK  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [11:0] iRed,
    input  logic [11:0] iGreen,
    input  logic [11:0] iBlue,
    input  logic        iVALID,
    output logic        oREADY,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oFRAME_DONE
);

    localparam int unsigned BlankMax = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned BlankW   = (BlankMax > 1) ? $clog2(BlankMax) : 1;

    localparam logic [BlankW-1:0] HLoad   = BlankW'(H_BLANK - 1);
    localparam logic [BlankW-1:0] VLoad   = BlankW'(V_BLANK - 1);
    localparam logic [10:0]       ColLast = 11'(H_ACTIVE - 1);
    localparam logic [10:0]       RowLast = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHblank,
        StVblank
    } state_e;

    state_e             state_q, state_d;
    logic [10:0]        col_q, col_d;
    logic [10:0]        row_q, row_d;
    logic [BlankW-1:0]  blank_q, blank_d;
    logic [11:0]        data_q, data_d;
    logic               dval_q, dval_d;
    logic [10:0]        x_q, x_d;
    logic [10:0]        y_q, y_d;
    logic               done_q, done_d;
    logic               xfer;
    logic [11:0]        mosaic;

    assign oREADY = (state_q == StActive);
    assign xfer   = iVALID && oREADY;

    // GRBG: even rows G,R,G,R...; odd rows B,G,B,G...
    always_comb begin
        mosaic = iGreen;
        case ({row_q[0], col_q[0]})
            2'b01:   mosaic = iRed;
            2'b10:   mosaic = iBlue;
            default: mosaic = iGreen;
        endcase
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        blank_d = blank_q;
        data_d  = data_q;
        dval_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (iEN) begin
                    state_d = StActive;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StActive: begin
                if (xfer) begin
                    dval_d = 1'b1;
                    data_d = mosaic;
                    x_d    = col_q;
                    y_d    = row_q;
                    if (col_q == ColLast) begin
                        col_d   = '0;
                        blank_d = HLoad;
                        state_d = StHblank;
                    end else begin
                        col_d = col_q + 11'd1;
                    end
                end
            end
            StHblank: begin
                if (blank_q == '0) begin
                    if (row_q < RowLast) begin
                        row_d   = row_q + 11'd1;
                        state_d = StActive;
                    end else begin
                        row_d   = '0;
                        blank_d = VLoad;
                        state_d = StVblank;
                    end
                end else begin
                    blank_d = blank_q - BlankW'(1);
                end
            end
            StVblank: begin
                if (blank_q == '0) begin
                    done_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = iEN ? StActive : StIdle;
                end else begin
                    blank_d = blank_q - BlankW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            blank_q <= '0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            blank_q <= blank_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_rgb_to_bayer_tx.sv
// Bench for rgb_to_bayer_tx: scoreboard of expected Bayer samples plus directed timing checks.
module tb_rgb_to_bayer_tx;

    localparam int unsigned HA = 4;
    localparam int unsigned VA = 2;
    localparam int unsigned HB = 2;
    localparam int unsigned VB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] red = '0;
    logic [11:0] green = '0;
    logic [11:0] blue = '0;
    logic        ready;
    logic [11:0] data;
    logic        dval;
    logic [10:0] xc;
    logic [10:0] yc;
    logic        done;

    always #5 clk = ~clk;

    rgb_to_bayer_tx #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iEN         (en),
        .iRed        (red),
        .iGreen      (green),
        .iBlue       (blue),
        .iVALID      (valid),
        .oREADY      (ready),
        .oDATA       (data),
        .oDVAL       (dval),
        .oX_Cont     (xc),
        .oY_Cont     (yc),
        .oFRAME_DONE (done)
    );

    typedef struct packed {
        logic [11:0] d;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned idx = 0;
    int unsigned xfers = 0;
    logic [11:0] last_d = '0;
    logic [10:0] last_x = '0;
    logic [10:0] last_y = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: k-th pixel of a frame sits at (k mod H, k div H); GRBG colour by parity.
    function automatic logic [11:0] bayer(input int unsigned x, input int unsigned y,
                                          input logic [11:0] r, input logic [11:0] g,
                                          input logic [11:0] b);
        if (y % 2 == 0) return (x % 2 == 0) ? g : r;
        else            return (x % 2 == 0) ? b : g;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            idx    = 0;
            last_d = '0;
            last_x = '0;
            last_y = '0;
        end else if (valid && ready) begin
            e.x = 11'(idx % HA);
            e.y = 11'(idx / HA);
            e.d = bayer(idx % HA, idx / HA, red, green, blue);
            exp_q.push_back(e);
            idx = (idx + 1) % (HA * VA);
            xfers++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dval) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected sample: got data=%0h x=%0d y=%0d, expected none",
                         data, xc, yc);
            end else begin
                e = exp_q.pop_front();
                check("sample data", 32'(data), 32'(e.d));
                check("sample x", 32'(xc), 32'(e.x));
                check("sample y", 32'(yc), 32'(e.y));
            end
            last_d = data;
            last_x = xc;
            last_y = yc;
        end else begin
            check("hold while idle", {data, xc, yc}, {last_d, last_x, last_y});
        end
        check("latency pending", exp_q.size(), 0);
        exp_q.delete();
    end

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 1);
    endtask

    task automatic wait_sample(input string name, input int unsigned x, input int unsigned y);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dval && xc == 11'(x) && yc == 11'(y)) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 1);
    endtask

    initial begin
        int          nd;
        int unsigned xf0;
        bit          seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset ready", 32'(ready), 0);
        check("reset dval", 32'(dval), 0);
        check("reset data", 32'(data), 0);
        check("reset x", 32'(xc), 0);
        check("reset y", 32'(yc), 0);
        check("reset done", 32'(done), 0);
        rst = 1'b0;

        // Full frame with constant colours and back-to-back restart
        do_reset();
        red = 12'h100; green = 12'h200; blue = 12'h300;
        en = 1'b1; valid = 1'b1;
        wait_ready("frame first ready");
        for (int i = 0; i < 16; i++) begin
            check("frame ready pattern", 32'(ready),
                  32'((i < 4) || (i >= 6 && i < 10) || (i == 15)));
            check("frame done pattern", 32'(done), 32'(i == 15));
            @(negedge clk);
        end
        check("back-to-back first sample y", 32'(yc), 0);
        check("back-to-back first sample x", 32'(xc), 0);
        check("back-to-back first sample dval", 32'(dval), 1);

        // Stall after the second transfer
        do_reset();
        red = 12'h111; green = 12'h222; blue = 12'h333;
        en = 1'b1;
        wait_ready("stall first ready");
        valid = 1'b1;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall dval low", 32'(dval), 0);
            check("stall x held", 32'(xc), 1);
        end
        valid = 1'b1;
        @(negedge clk);
        check("stall resume dval", 32'(dval), 1);
        check("stall resume x", 32'(xc), 2);

        // iEN dropped mid-frame: frame completes, then stays idle
        do_reset();
        red = 12'h0a1; green = 12'h0b2; blue = 12'h0c3;
        en = 1'b1; valid = 1'b1;
        wait_sample("en-drop reach (1,1)", 1, 1);
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("en-drop frame done", 32'(seen), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("en-drop idle ready", 32'(ready), 0);
            check("en-drop no done", 32'(done), 0);
        end

        // Reset at row 1 col 2
        do_reset();
        red = 12'habc; green = 12'hdef; blue = 12'h123;
        en = 1'b1; valid = 1'b1;
        wait_sample("reset-mid reach (1,1)", 1, 1);
        rst = 1'b1;
        @(negedge clk);
        check("reset-mid ready", 32'(ready), 0);
        check("reset-mid dval", 32'(dval), 0);
        check("reset-mid data", 32'(data), 0);
        check("reset-mid x", 32'(xc), 0);
        check("reset-mid y", 32'(yc), 0);
        check("reset-mid done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("reset-mid restart ready", 32'(ready), 1);
        @(negedge clk);
        check("reset-mid first dval", 32'(dval), 1);
        check("reset-mid first x", 32'(xc), 0);
        check("reset-mid first y", 32'(yc), 0);
        check("reset-mid first data", 32'(data), 32'h0def);

        // Random valid and colours over 100 frames
        do_reset();
        en  = 1'b1;
        nd  = 0;
        xf0 = xfers;
        for (int c = 0; c < 20000 && nd < 100; c++) begin
            valid = 1'($urandom_range(0, 1));
            red   = 12'($urandom);
            green = 12'($urandom);
            blue  = 12'($urandom);
            @(negedge clk);
            if (done) nd++;
        end
        check("random frames done", 32'(nd), 100);
        check("random transfers", xfers - xf0, 100 * HA * VA);

        do_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rgb_to_bayer_tx.md
RGB_TO_BAYER_TX -- requirements
Module: rgb_to_bayer_tx

Interface
- REQ-001: Parameter H_ACTIVE, default 1280, SHALL be the active pixels per line (range 2..2047).
- REQ-002: Parameter V_ACTIVE, default 960, SHALL be the active lines per frame (range 2..2047).
- REQ-003: Parameter H_BLANK, default 16, SHALL be the idle cycles after each line (minimum 1).
- REQ-004: Parameter V_BLANK, default 4, SHALL be the idle cycles after the last line's blanking (minimum 1).
- REQ-005: iCLK  in  1  SHALL be the single clock; all logic is rising-edge.
- REQ-006: iRST  in  1  SHALL be the reset: synchronous, active-high.
- REQ-007: iEN  in  1  SHALL be the level enable that permits a new frame to start.
- REQ-008: iRed, iGreen, iBlue  in  12 each  SHALL be the RGB pixel to transmit.
- REQ-009: iVALID  in  1  SHALL indicate that the iRed/iGreen/iBlue pixel is valid.
- REQ-010: oREADY  out  1  SHALL indicate that the block accepts a pixel this cycle.
- REQ-011: oDATA  out  12  SHALL be the raw Bayer sample.
- REQ-012: oDVAL  out  1  SHALL be the raw sample valid strobe.
- REQ-013: oX_Cont, oY_Cont  out  11 each  SHALL be the column and row of the sample on oDATA.
- REQ-014: oFRAME_DONE  out  1  SHALL be a one-cycle pulse at the end of vertical blanking.

Function
- REQ-015: The FSM SHALL have the states IDLE, ACTIVE, HBLANK and VBLANK.
- REQ-016: oREADY SHALL equal (state==ACTIVE), decoded from registered state only, with no combinational path from iVALID.
- REQ-017: A transfer SHALL occur on each cycle where iVALID&&oREADY; no other cycle consumes input.
- REQ-018: IDLE->ACTIVE SHALL occur when iEN=1; column and row counters are 0 on entry.
- REQ-019: Each transfer SHALL increment the column counter; no transfer in ACTIVE (stall) SHALL hold both counters and the state.
- REQ-020: A transfer at column H_ACTIVE-1 SHALL clear the column counter and move ACTIVE->HBLANK.
- REQ-021: HBLANK SHALL last exactly H_BLANK cycles.
- REQ-022: On HBLANK exit, if row < V_ACTIVE-1, the row counter SHALL increment and the FSM SHALL go to ACTIVE; otherwise the row counter SHALL clear and the FSM SHALL go to VBLANK.
- REQ-023: VBLANK SHALL last exactly V_BLANK cycles; in its final cycle oFRAME_DONE SHALL be registered high for the next cycle.
- REQ-024: On VBLANK exit, the FSM SHALL go to ACTIVE if iEN=1 (back-to-back frame), else to IDLE.
- REQ-025: iEN deasserted mid-frame SHALL NOT abort the frame; it is sampled only in IDLE and at VBLANK exit.
- REQ-026: Mosaic, with the pattern chosen by the transferred pixel's (row[0], col[0]) (GRBG):
  - (0,0) -> iGreen
  - (0,1) -> iRed
  - (1,0) -> iBlue
  - (1,1) -> iGreen
- REQ-027: Latency SHALL be 1 cycle: oDATA, oDVAL=1, oX_Cont and oY_Cont are registered on the cycle after the transfer.
- REQ-028: oDVAL SHALL be 0 on every cycle not following a transfer.
- REQ-029: oDATA, oX_Cont and oY_Cont SHALL hold their last values while oDVAL=0.
- REQ-030: No value truncation is needed: sample width equals channel width (12 bits); counters are 11 bits.
- REQ-031: Blanking counters SHALL be sized to the clog2 of the larger of H_BLANK and V_BLANK, and SHALL be reloaded on each state entry.
- REQ-032: Output stream conformance: oX_Cont SHALL be strictly sequential 0..H_ACTIVE-1 per line and oY_Cont 0..V_ACTIVE-1 per frame, so a downstream raw-Bayer consumer's parity decode matches REQ-026.

Reset
- REQ-033: While iRST=1 at a clock edge, the following SHALL be forced:
  - state=IDLE
  - all counters=0
  - oREADY=0, oDVAL=0, oFRAME_DONE=0
  - oDATA=0, oX_Cont=0, oY_Cont=0
- REQ-034: Reset mid-frame SHALL discard the partial frame; after release with iEN=1, the next frame SHALL start at (0,0) on the following cycle.
- REQ-035: Reset SHALL take priority over iEN, iVALID and any transition.

Verification (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_BLANK=3)
- REQ-036: Full frame: iEN=1, iVALID=1 constant, R=0x100, G=0x200, B=0x300 -> row0 oDATA=200,100,200,100; 2 idle cycles; row1 oDATA=300,200,300,200; 2+3 idle cycles; oFRAME_DONE pulses once; frame total 15 cycles from first oREADY.
- REQ-037: Stall: iVALID low for 3 cycles after 2nd transfer -> oDVAL low 3 cycles, oX_Cont holds at 1, next sample has oX_Cont=2 with no skipped or duplicated coordinate.
- REQ-038: iEN dropped at row 1 col 1 -> frame completes and oFRAME_DONE pulses, then IDLE with oREADY=0 indefinitely.
- REQ-039: Back-to-back: iEN held high -> oREADY reasserts the cycle after the last VBLANK cycle and the new frame starts with oY_Cont=0, oX_Cont=0.
- REQ-040: Reset at row 1 col 2 -> the next cycle shows all outputs 0 and oREADY=0; after release, the first sample is (0,0) with oDATA=iGreen.
- REQ-041: Random iVALID (50%) for 100 frames against a golden model -> the coordinate sequence and the channel selection per REQ-026 match exactly.
